// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register and imem address, and holds the F/D slot.
// state | meaning
// RUN   | fetching, one instruction per cycle unless stalled
// HALT  | fetch stopped, F/D holds a bubble until resume or redirect
module fetch_unit #(
    parameter int IMEM_AW = 12,
    parameter int DW      = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [31:0]        pc_q,
    output logic [31:0]        next_pc,
    output logic               pc_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [DW-1:0]      imem_q,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               halt_req,
    input  logic               resume,
    output logic               fd_valid,
    output logic [DW-1:0]      fd_instr,
    output logic [31:0]        fd_pc,
    output logic [31:0]        fd_pc_plus1,
    output logic               halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pc_plus1;
    logic        running;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= RUN;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        if (redirect) begin
            state_d      = RUN;
            pend_valid_d = 1'b0;
        end else if (halt_req) begin
            state_d      = HALT;
            pend_valid_d = 1'b0;
        end else if (state_q == HALT) begin
            pend_valid_d = 1'b0;
            if (resume) begin
                state_d = RUN;
            end
        end else if (!stall) begin
            pend_pc_d    = pc_q;
            pend_valid_d = 1'b1;
        end
    end

    // While clr is held the PC path behaves as a plain free-running fetch.
    always_comb begin
        pc_plus1  = pc_q + 32'd1;
        running   = (state_q == RUN);
        next_pc   = pc_plus1;
        pc_en     = 1'b1;
        imem_addr = pc_q[IMEM_AW-1:0];
        if (!clr) begin
            next_pc = redirect ? redirect_target : pc_plus1;
            pc_en   = redirect | (running & ~stall & ~halt_req);
            if (stall && !redirect && running) begin
                imem_addr = pend_pc_q[IMEM_AW-1:0];
            end
        end
    end

    assign fd_valid    = pend_valid_q;
    assign fd_instr    = pend_valid_q ? imem_q : '0;
    assign fd_pc       = pend_pc_q;
    assign fd_pc_plus1 = pend_pc_q + 32'd1;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and imem models, directed stimulus, queue-based scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        clr;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        pc_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_q = '0;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus1;
    logic        halted;

    logic [31:0] pc_rst_val = 32'h0;
    logic [31:0] mem [0:4095];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus1;
    } exp_t;
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.IMEM_AW(12), .DW(32)) dut (
        .clk(clk), .clr(clr), .pc_q(pc_q), .next_pc(next_pc), .pc_en(pc_en),
        .imem_addr(imem_addr), .imem_q(imem_q), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
        .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc(fd_pc),
        .fd_pc_plus1(fd_pc_plus1), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pc_q = 32'h0;
    always @(posedge clk or posedge clr) begin
        if (clr) pc_q <= pc_rst_val;
        else if (pc_en) pc_q <= next_pc;
    end

    initial for (int k = 0; k < 4096; k++) mem[k] = 32'h1000 + k;
    always @(posedge clk) imem_q <= mem[imem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] plus1);
        exp_t e;
        e.pc = pc; e.instr = instr; e.plus1 = plus1;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode consumes the F/D slot whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!clr && fd_valid && !stall) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got fd_pc %h expected no instruction", fd_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_fd_pc", fd_pc, e.pc);
                chk("sb_fd_instr", fd_instr, e.instr);
                chk("sb_fd_pc_plus1", fd_pc_plus1, e.plus1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fd_valid", {31'b0, fd_valid}, 32'd0);
        chk("rst_fd_instr", fd_instr, 32'd0);
        chk("rst_fd_pc", fd_pc, 32'd0);
        chk("rst_fd_pc_plus1", fd_pc_plus1, 32'd1);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_next_pc", next_pc, 32'd1);
        chk("rst_pc_en", {31'b0, pc_en}, 32'd1);
        chk("rst_imem_addr", {20'b0, imem_addr}, 32'd0);

        @(posedge clk); #1 clr = 1'b0;
        push(32'h0, 32'h1000, 32'h1);
        push(32'h1, 32'h1001, 32'h2);
        push(32'h2, 32'h1002, 32'h3);
        @(negedge clk);
        chk("c0_fd_valid", {31'b0, fd_valid}, 32'd0);
        chk("c0_next_pc", next_pc, 32'd1);
        step();
        @(negedge clk);
        chk("c1_fd_pc", fd_pc, 32'h0);
        chk("c1_fd_instr", fd_instr, 32'h1000);
        step();
        step(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_fd_pc", fd_pc, 32'h2);
            chk("stall_fd_instr", fd_instr, 32'h1002);
            chk("stall_pc_en", {31'b0, pc_en}, 32'd0);
            chk("stall_imem_addr", {20'b0, imem_addr}, 32'h2);
            step();
        end
        stall = 1'b0;
        push(32'h3, 32'h1003, 32'h4);
        push(32'h4, 32'h1004, 32'h5);
        push(32'h5, 32'h1005, 32'h6);
        step();
        @(negedge clk);
        chk("post_stall_fd_pc", fd_pc, 32'h3);
        step();
        step(); redirect = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        chk("redir_pc_en", {31'b0, pc_en}, 32'd1);
        chk("redir_next_pc", next_pc, 32'h40);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("redir_bubble_valid", {31'b0, fd_valid}, 32'd0);
        chk("redir_bubble_instr", fd_instr, 32'd0);
        push(32'h40, 32'h1040, 32'h41);
        step();
        @(negedge clk);
        chk("redir_tgt_fd_pc", fd_pc, 32'h40);
        step(); redirect = 1'b1; stall = 1'b1; redirect_target = 32'h80;
        @(negedge clk);
        chk("redir_stall_imem_addr", {20'b0, imem_addr}, 32'h42);
        chk("redir_stall_pc_en", {31'b0, pc_en}, 32'd1);
        step(); redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("redir_stall_bubble", {31'b0, fd_valid}, 32'd0);
        push(32'h80, 32'h1080, 32'h81);
        push(32'h81, 32'h1081, 32'h82);
        step();
        step(); halt_req = 1'b1;
        @(negedge clk);
        chk("halt_req_pc_en", {31'b0, pc_en}, 32'd0);
        step(); halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_halted", {31'b0, halted}, 32'd1);
            chk("halt_fd_valid", {31'b0, fd_valid}, 32'd0);
            chk("halt_pc_en", {31'b0, pc_en}, 32'd0);
            chk("halt_pc", pc_q, 32'h82);
            step();
        end
        resume = 1'b1;
        @(negedge clk);
        chk("resume_halted", {31'b0, halted}, 32'd1);
        chk("resume_pc_en", {31'b0, pc_en}, 32'd0);
        step(); resume = 1'b0;
        @(negedge clk);
        chk("run_halted", {31'b0, halted}, 32'd0);
        chk("run_fd_valid", {31'b0, fd_valid}, 32'd0);
        chk("run_pc_en", {31'b0, pc_en}, 32'd1);
        push(32'h82, 32'h1082, 32'h83);
        push(32'h83, 32'h1083, 32'h84);
        step();
        @(negedge clk);
        chk("resume_fd_pc", fd_pc, 32'h82);
        chk("resume_fd_valid", {31'b0, fd_valid}, 32'd1);
        step(); halt_req = 1'b1; redirect = 1'b1; redirect_target = 32'h100;
        step(); halt_req = 1'b0; redirect = 1'b0;
        @(negedge clk);
        chk("hr_halted", {31'b0, halted}, 32'd0);
        chk("hr_fd_valid", {31'b0, fd_valid}, 32'd0);
        push(32'h100, 32'h1100, 32'h101);
        step();
        @(negedge clk);
        chk("hr_tgt_fd_pc", fd_pc, 32'h100);
        step(); stall = 1'b1;
        pc_rst_val = 32'hFFFF_FFFF;
        #3 clr = 1'b1;
        #1;
        chk("midrst_fd_valid", {31'b0, fd_valid}, 32'd0);
        chk("midrst_halted", {31'b0, halted}, 32'd0);
        chk("midrst_fd_pc", fd_pc, 32'd0);
        chk("midrst_pc_en", {31'b0, pc_en}, 32'd1);
        stall = 1'b0;
        @(posedge clk); #1 clr = 1'b0;
        push(32'hFFFF_FFFF, 32'h1FFF, 32'h0);
        push(32'h0, 32'h1000, 32'h1);
        @(negedge clk);
        chk("wrap_next_pc", next_pc, 32'h0);
        chk("wrap_imem_addr", {20'b0, imem_addr}, 32'hFFF);
        step();
        @(negedge clk);
        chk("wrap_fd_pc_plus1", fd_pc_plus1, 32'h0);
        step();
        @(negedge clk);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
